// File: rtl/iob_cache_ctrl_stats_pkg.sv
// Shared constants and types for the cache control statistics back-end.
// Holds the default counter width, counter slot indices, invalidate FSM
// state encoding and a small helper that sums two event pulses.
package iob_cache_ctrl_stats_pkg;

  localparam int CNT_W_DEFAULT = 32;
  localparam int NUM_CNT       = 6;

  // Slot order of the six counters inside the back-end arrays
  localparam int CNT_RW_HIT     = 0;
  localparam int CNT_RW_MISS    = 1;
  localparam int CNT_READ_HIT   = 2;
  localparam int CNT_READ_MISS  = 3;
  localparam int CNT_WRITE_HIT  = 4;
  localparam int CNT_WRITE_MISS = 5;

  typedef enum logic [1:0] {
    INV_IDLE  = 2'd0,
    INV_DRAIN = 2'd1,
    INV_INV   = 2'd2
  } inv_state_t;

  // Sum of two single-bit events: 0, 1 or 2
  function automatic logic [1:0] add2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/iob_cache_ctrl_stats_event_cnt.sv
// Event counter with synchronous clear priority.
// Ports: clk_i/cke_i/arst_i clocking, clr_i synchronous clear (wins over
// any increment), inc_i increment of 0..2, cnt_o current count.
// Arithmetic wraps modulo 2^CNT_W.
module iob_cache_ctrl_stats_event_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             arst_i,
  input  logic             clr_i,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_o <= '0;
    end else if (cke_i) begin
      if (clr_i) begin
        cnt_o <= '0;
      end else begin
        cnt_o <= cnt_o + CNT_W'(inc_i);
      end
    end
  end

endmodule

// File: rtl/iob_cache_ctrl_stats.sv
// Statistics and maintenance back-end for the cache control register bank.
// Ports:
//   clk_i, cke_i, arst_i             clock, clock enable, async reset
//   read/write hit/miss event pulses from the cache front-end
//   wtb_empty_i, wtb_full_i          write-through buffer status
//   <REG>_ren_i/_rdata_o/_rvalid_o/_rready_o   register bank read ports
//   RST_CNTRS_*                      counter clear write port
//   INVALIDATE_*                     invalidate request write port
//   invalidate_o                     one-cycle invalidate to tag/valid memory
module iob_cache_ctrl_stats
  import iob_cache_ctrl_stats_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int USE_CTRL_CNT = 1
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             arst_i,
  input  logic             read_hit_i,
  input  logic             read_miss_i,
  input  logic             write_hit_i,
  input  logic             write_miss_i,
  input  logic             wtb_empty_i,
  input  logic             wtb_full_i,
  input  logic             WTB_EMPTY_ren_i,
  output logic             WTB_EMPTY_rdata_o,
  output logic             WTB_EMPTY_rvalid_o,
  output logic             WTB_EMPTY_rready_o,
  input  logic             WTB_FULL_ren_i,
  output logic             WTB_FULL_rdata_o,
  output logic             WTB_FULL_rvalid_o,
  output logic             WTB_FULL_rready_o,
  input  logic             RW_HIT_ren_i,
  output logic [CNT_W-1:0] RW_HIT_rdata_o,
  output logic             RW_HIT_rvalid_o,
  output logic             RW_HIT_rready_o,
  input  logic             RW_MISS_ren_i,
  output logic [CNT_W-1:0] RW_MISS_rdata_o,
  output logic             RW_MISS_rvalid_o,
  output logic             RW_MISS_rready_o,
  input  logic             READ_HIT_ren_i,
  output logic [CNT_W-1:0] READ_HIT_rdata_o,
  output logic             READ_HIT_rvalid_o,
  output logic             READ_HIT_rready_o,
  input  logic             READ_MISS_ren_i,
  output logic [CNT_W-1:0] READ_MISS_rdata_o,
  output logic             READ_MISS_rvalid_o,
  output logic             READ_MISS_rready_o,
  input  logic             WRITE_HIT_ren_i,
  output logic [CNT_W-1:0] WRITE_HIT_rdata_o,
  output logic             WRITE_HIT_rvalid_o,
  output logic             WRITE_HIT_rready_o,
  input  logic             WRITE_MISS_ren_i,
  output logic [CNT_W-1:0] WRITE_MISS_rdata_o,
  output logic             WRITE_MISS_rvalid_o,
  output logic             WRITE_MISS_rready_o,
  input  logic             RST_CNTRS_wdata_i,
  input  logic             RST_CNTRS_wen_i,
  output logic             RST_CNTRS_wready_o,
  input  logic             INVALIDATE_wdata_i,
  input  logic             INVALIDATE_wen_i,
  output logic             INVALIDATE_wready_o,
  output logic             invalidate_o
);

  logic [NUM_CNT-1:0] ren;
  logic [1:0]         inc      [NUM_CNT];
  logic [CNT_W-1:0]   cnt      [NUM_CNT];
  logic [CNT_W-1:0]   rdata_q  [NUM_CNT];
  logic [NUM_CNT-1:0] rvalid_q;
  logic               clr;
  logic [1:0]         wtb_ren;
  logic [1:0]         wtb_rdata_q;
  logic [1:0]         wtb_rvalid_q;
  inv_state_t         state, state_nxt;

  assign ren = {WRITE_MISS_ren_i, WRITE_HIT_ren_i, READ_MISS_ren_i,
                READ_HIT_ren_i, RW_MISS_ren_i, RW_HIT_ren_i};
  assign wtb_ren = {WTB_FULL_ren_i, WTB_EMPTY_ren_i};
  assign clr = RST_CNTRS_wen_i & RST_CNTRS_wdata_i;

  assign inc[CNT_RW_HIT]     = add2(read_hit_i, write_hit_i);
  assign inc[CNT_RW_MISS]    = add2(read_miss_i, write_miss_i);
  assign inc[CNT_READ_HIT]   = {1'b0, read_hit_i};
  assign inc[CNT_READ_MISS]  = {1'b0, read_miss_i};
  assign inc[CNT_WRITE_HIT]  = {1'b0, write_hit_i};
  assign inc[CNT_WRITE_MISS] = {1'b0, write_miss_i};

  // Counters exist only when enabled; otherwise every slot reads as zero
  // while the read handshakes below keep responding.
  generate
    if (USE_CTRL_CNT != 0) begin : g_cnt
      for (genvar i = 0; i < NUM_CNT; i++) begin : g_inst
        iob_cache_ctrl_stats_event_cnt #(.CNT_W(CNT_W)) u_cnt (
          .clk_i (clk_i),
          .cke_i (cke_i),
          .arst_i(arst_i),
          .clr_i (clr),
          .inc_i (inc[i]),
          .cnt_o (cnt[i])
        );
      end
    end else begin : g_no_cnt
      for (genvar i = 0; i < NUM_CNT; i++) begin : g_zero
        assign cnt[i] = '0;
      end
    end
  endgenerate

  // Read holding registers capture the pre-increment value on ren and keep
  // it until the next ren; rvalid is ren delayed by one enabled cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rvalid_q     <= '0;
      wtb_rvalid_q <= '0;
      wtb_rdata_q  <= '0;
      for (int i = 0; i < NUM_CNT; i++) rdata_q[i] <= '0;
    end else if (cke_i) begin
      rvalid_q     <= ren;
      wtb_rvalid_q <= wtb_ren;
      if (wtb_ren[0]) wtb_rdata_q[0] <= wtb_empty_i;
      if (wtb_ren[1]) wtb_rdata_q[1] <= wtb_full_i;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (ren[i]) rdata_q[i] <= cnt[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= INV_IDLE;
    end else if (cke_i) begin
      state <= state_nxt;
    end
  end

  // DRAIN is always visited, even with an empty buffer, so the invalidate
  // never overtakes a write still sitting in the write-through buffer.
  always_comb begin
    state_nxt           = state;
    invalidate_o        = 1'b0;
    INVALIDATE_wready_o = 1'b0;
    case (state)
      INV_IDLE: begin
        INVALIDATE_wready_o = 1'b1;
        if (INVALIDATE_wen_i && INVALIDATE_wdata_i) state_nxt = INV_DRAIN;
      end
      INV_DRAIN: begin
        if (wtb_empty_i) state_nxt = INV_INV;
      end
      INV_INV: begin
        invalidate_o = 1'b1;
        state_nxt    = INV_IDLE;
      end
      default: state_nxt = INV_IDLE;
    endcase
  end

  assign RW_HIT_rdata_o      = rdata_q[CNT_RW_HIT];
  assign RW_MISS_rdata_o     = rdata_q[CNT_RW_MISS];
  assign READ_HIT_rdata_o    = rdata_q[CNT_READ_HIT];
  assign READ_MISS_rdata_o   = rdata_q[CNT_READ_MISS];
  assign WRITE_HIT_rdata_o   = rdata_q[CNT_WRITE_HIT];
  assign WRITE_MISS_rdata_o  = rdata_q[CNT_WRITE_MISS];
  assign RW_HIT_rvalid_o     = rvalid_q[CNT_RW_HIT];
  assign RW_MISS_rvalid_o    = rvalid_q[CNT_RW_MISS];
  assign READ_HIT_rvalid_o   = rvalid_q[CNT_READ_HIT];
  assign READ_MISS_rvalid_o  = rvalid_q[CNT_READ_MISS];
  assign WRITE_HIT_rvalid_o  = rvalid_q[CNT_WRITE_HIT];
  assign WRITE_MISS_rvalid_o = rvalid_q[CNT_WRITE_MISS];
  assign RW_HIT_rready_o     = 1'b1;
  assign RW_MISS_rready_o    = 1'b1;
  assign READ_HIT_rready_o   = 1'b1;
  assign READ_MISS_rready_o  = 1'b1;
  assign WRITE_HIT_rready_o  = 1'b1;
  assign WRITE_MISS_rready_o = 1'b1;
  assign WTB_EMPTY_rdata_o   = wtb_rdata_q[0];
  assign WTB_FULL_rdata_o    = wtb_rdata_q[1];
  assign WTB_EMPTY_rvalid_o  = wtb_rvalid_q[0];
  assign WTB_FULL_rvalid_o   = wtb_rvalid_q[1];
  assign WTB_EMPTY_rready_o  = 1'b1;
  assign WTB_FULL_rready_o   = 1'b1;
  assign RST_CNTRS_wready_o  = 1'b1;

endmodule

// File: tb/tb_iob_cache_ctrl_stats.sv
// Directed bench for iob_cache_ctrl_stats. Three instances share one stimulus:
// the default 32-bit configuration, a 4-bit configuration for counter wrap,
// and a configuration with the counters removed.
module tb_iob_cache_ctrl_stats;

  logic clk, cke, arst;
  logic rh, rm, wh, wm;
  logic wtb_empty, wtb_full;
  logic [1:0] wtb_ren;
  logic [5:0] ren;
  logic rst_wdata, rst_wen, inv_wdata, inv_wen;

  logic [31:0] rd_m [6];
  logic [3:0]  rd_s [6];
  logic [31:0] rd_n [6];
  logic [5:0]  rv_m, rr_m, rv_s, rr_s, rv_n, rr_n;
  logic [1:0]  wtb_rd_m, wtb_rv_m, wtb_rr_m;
  logic [1:0]  wtb_rd_s, wtb_rv_s, wtb_rr_s;
  logic [1:0]  wtb_rd_n, wtb_rv_n, wtb_rr_n;
  logic        rst_wr_m, inv_wr_m, inv_m;
  logic        rst_wr_s, inv_wr_s, inv_s;
  logic        rst_wr_n, inv_wr_n, inv_n;

  int checks;
  int errors;

  iob_cache_ctrl_stats #(.CNT_W(32), .USE_CTRL_CNT(1)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .wtb_empty_i(wtb_empty), .wtb_full_i(wtb_full),
    .WTB_EMPTY_ren_i(wtb_ren[0]), .WTB_EMPTY_rdata_o(wtb_rd_m[0]), .WTB_EMPTY_rvalid_o(wtb_rv_m[0]), .WTB_EMPTY_rready_o(wtb_rr_m[0]),
    .WTB_FULL_ren_i(wtb_ren[1]), .WTB_FULL_rdata_o(wtb_rd_m[1]), .WTB_FULL_rvalid_o(wtb_rv_m[1]), .WTB_FULL_rready_o(wtb_rr_m[1]),
    .RW_HIT_ren_i(ren[0]), .RW_HIT_rdata_o(rd_m[0]), .RW_HIT_rvalid_o(rv_m[0]), .RW_HIT_rready_o(rr_m[0]),
    .RW_MISS_ren_i(ren[1]), .RW_MISS_rdata_o(rd_m[1]), .RW_MISS_rvalid_o(rv_m[1]), .RW_MISS_rready_o(rr_m[1]),
    .READ_HIT_ren_i(ren[2]), .READ_HIT_rdata_o(rd_m[2]), .READ_HIT_rvalid_o(rv_m[2]), .READ_HIT_rready_o(rr_m[2]),
    .READ_MISS_ren_i(ren[3]), .READ_MISS_rdata_o(rd_m[3]), .READ_MISS_rvalid_o(rv_m[3]), .READ_MISS_rready_o(rr_m[3]),
    .WRITE_HIT_ren_i(ren[4]), .WRITE_HIT_rdata_o(rd_m[4]), .WRITE_HIT_rvalid_o(rv_m[4]), .WRITE_HIT_rready_o(rr_m[4]),
    .WRITE_MISS_ren_i(ren[5]), .WRITE_MISS_rdata_o(rd_m[5]), .WRITE_MISS_rvalid_o(rv_m[5]), .WRITE_MISS_rready_o(rr_m[5]),
    .RST_CNTRS_wdata_i(rst_wdata), .RST_CNTRS_wen_i(rst_wen), .RST_CNTRS_wready_o(rst_wr_m),
    .INVALIDATE_wdata_i(inv_wdata), .INVALIDATE_wen_i(inv_wen), .INVALIDATE_wready_o(inv_wr_m),
    .invalidate_o(inv_m)
  );

  iob_cache_ctrl_stats #(.CNT_W(4), .USE_CTRL_CNT(1)) dut_small (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .wtb_empty_i(wtb_empty), .wtb_full_i(wtb_full),
    .WTB_EMPTY_ren_i(wtb_ren[0]), .WTB_EMPTY_rdata_o(wtb_rd_s[0]), .WTB_EMPTY_rvalid_o(wtb_rv_s[0]), .WTB_EMPTY_rready_o(wtb_rr_s[0]),
    .WTB_FULL_ren_i(wtb_ren[1]), .WTB_FULL_rdata_o(wtb_rd_s[1]), .WTB_FULL_rvalid_o(wtb_rv_s[1]), .WTB_FULL_rready_o(wtb_rr_s[1]),
    .RW_HIT_ren_i(ren[0]), .RW_HIT_rdata_o(rd_s[0]), .RW_HIT_rvalid_o(rv_s[0]), .RW_HIT_rready_o(rr_s[0]),
    .RW_MISS_ren_i(ren[1]), .RW_MISS_rdata_o(rd_s[1]), .RW_MISS_rvalid_o(rv_s[1]), .RW_MISS_rready_o(rr_s[1]),
    .READ_HIT_ren_i(ren[2]), .READ_HIT_rdata_o(rd_s[2]), .READ_HIT_rvalid_o(rv_s[2]), .READ_HIT_rready_o(rr_s[2]),
    .READ_MISS_ren_i(ren[3]), .READ_MISS_rdata_o(rd_s[3]), .READ_MISS_rvalid_o(rv_s[3]), .READ_MISS_rready_o(rr_s[3]),
    .WRITE_HIT_ren_i(ren[4]), .WRITE_HIT_rdata_o(rd_s[4]), .WRITE_HIT_rvalid_o(rv_s[4]), .WRITE_HIT_rready_o(rr_s[4]),
    .WRITE_MISS_ren_i(ren[5]), .WRITE_MISS_rdata_o(rd_s[5]), .WRITE_MISS_rvalid_o(rv_s[5]), .WRITE_MISS_rready_o(rr_s[5]),
    .RST_CNTRS_wdata_i(rst_wdata), .RST_CNTRS_wen_i(rst_wen), .RST_CNTRS_wready_o(rst_wr_s),
    .INVALIDATE_wdata_i(inv_wdata), .INVALIDATE_wen_i(inv_wen), .INVALIDATE_wready_o(inv_wr_s),
    .invalidate_o(inv_s)
  );

  iob_cache_ctrl_stats #(.CNT_W(32), .USE_CTRL_CNT(0)) dut_nocnt (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .read_hit_i(rh), .read_miss_i(rm), .write_hit_i(wh), .write_miss_i(wm),
    .wtb_empty_i(wtb_empty), .wtb_full_i(wtb_full),
    .WTB_EMPTY_ren_i(wtb_ren[0]), .WTB_EMPTY_rdata_o(wtb_rd_n[0]), .WTB_EMPTY_rvalid_o(wtb_rv_n[0]), .WTB_EMPTY_rready_o(wtb_rr_n[0]),
    .WTB_FULL_ren_i(wtb_ren[1]), .WTB_FULL_rdata_o(wtb_rd_n[1]), .WTB_FULL_rvalid_o(wtb_rv_n[1]), .WTB_FULL_rready_o(wtb_rr_n[1]),
    .RW_HIT_ren_i(ren[0]), .RW_HIT_rdata_o(rd_n[0]), .RW_HIT_rvalid_o(rv_n[0]), .RW_HIT_rready_o(rr_n[0]),
    .RW_MISS_ren_i(ren[1]), .RW_MISS_rdata_o(rd_n[1]), .RW_MISS_rvalid_o(rv_n[1]), .RW_MISS_rready_o(rr_n[1]),
    .READ_HIT_ren_i(ren[2]), .READ_HIT_rdata_o(rd_n[2]), .READ_HIT_rvalid_o(rv_n[2]), .READ_HIT_rready_o(rr_n[2]),
    .READ_MISS_ren_i(ren[3]), .READ_MISS_rdata_o(rd_n[3]), .READ_MISS_rvalid_o(rv_n[3]), .READ_MISS_rready_o(rr_n[3]),
    .WRITE_HIT_ren_i(ren[4]), .WRITE_HIT_rdata_o(rd_n[4]), .WRITE_HIT_rvalid_o(rv_n[4]), .WRITE_HIT_rready_o(rr_n[4]),
    .WRITE_MISS_ren_i(ren[5]), .WRITE_MISS_rdata_o(rd_n[5]), .WRITE_MISS_rvalid_o(rv_n[5]), .WRITE_MISS_rready_o(rr_n[5]),
    .RST_CNTRS_wdata_i(rst_wdata), .RST_CNTRS_wen_i(rst_wen), .RST_CNTRS_wready_o(rst_wr_n),
    .INVALIDATE_wdata_i(inv_wdata), .INVALIDATE_wen_i(inv_wen), .INVALIDATE_wready_o(inv_wr_n),
    .invalidate_o(inv_n)
  );

  // 10 ns clock; inputs change 1 ns after each rising edge
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle of events {rh,rm,wh,wm} and read strobes, then back to idle
  task automatic applyStimulus(input logic [3:0] ev, input logic [5:0] r);
    {rh, rm, wh, wm} = ev;
    ren = r;
    step();
    {rh, rm, wh, wm} = 4'b0;
    ren = '0;
  endtask

  // An invalidate write must only be issued while the FSM is idle
  always @(negedge clk) begin
    if (inv_wen) begin
      checks++;
      assert (inv_wr_m === 1'b1) else begin
        errors++;
        $error("[TB] FAIL proto_wen_busy: wready %b required 1", inv_wr_m);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cke = 1'b1;
    arst = 1'b1;
    {rh, rm, wh, wm} = 4'b0;
    wtb_empty = 1'b1;
    wtb_full = 1'b0;
    wtb_ren = '0;
    ren = '0;
    rst_wdata = 1'b0;
    rst_wen = 1'b0;
    inv_wdata = 1'b0;
    inv_wen = 1'b0;

    #2;
    $display("[TB] reset values");
    checkOutput("rst_rvalid", {26'd0, rv_m}, 32'd0);
    checkOutput("rst_rdata_rw_hit", rd_m[0], 32'd0);
    checkOutput("rst_rdata_wr_miss", rd_m[5], 32'd0);
    checkOutput("rst_wtb", {28'd0, wtb_rv_m, wtb_rd_m}, 32'd0);
    checkOutput("rst_rready", {24'd0, rr_m, wtb_rr_m}, 32'hFF);
    checkOutput("rst_fsm", {29'd0, inv_m, inv_wr_m, rst_wr_m}, 32'b011);
    #10 arst = 1'b0;
    step();

    $display("[TB] coincident hits");
    for (int i = 0; i < 5; i++) applyStimulus(4'b1010, 6'b0);
    ren = 6'b010101;
    checkOutput("rvalid_not_early", {26'd0, rv_m}, 32'd0);
    applyStimulus(4'b0000, 6'b010101);
    checkOutput("coin_rvalid", {26'd0, rv_m}, 32'b010101);
    checkOutput("coin_rw_hit", rd_m[0], 32'd10);
    checkOutput("coin_read_hit", rd_m[2], 32'd5);
    checkOutput("coin_write_hit", rd_m[4], 32'd5);
    checkOutput("nocnt_rvalid", {26'd0, rv_n}, 32'b010101);
    checkOutput("nocnt_rw_hit", rd_n[0], 32'd0);
    checkOutput("nocnt_read_hit", rd_n[2], 32'd0);

    $display("[TB] back-to-back reads, pre-increment capture");
    applyStimulus(4'b1000, 6'b000001);
    checkOutput("b2b_first", rd_m[0], 32'd10);
    checkOutput("b2b_first_valid", {31'd0, rv_m[0]}, 32'd1);
    applyStimulus(4'b0000, 6'b000001);
    checkOutput("b2b_second", rd_m[0], 32'd11);
    checkOutput("b2b_second_valid", {31'd0, rv_m[0]}, 32'd1);
    step();
    checkOutput("rvalid_drop", {26'd0, rv_m}, 32'd0);
    checkOutput("rdata_hold", rd_m[0], 32'd11);

    $display("[TB] misses and counter clear");
    applyStimulus(4'b0101, 6'b0);
    applyStimulus(4'b0101, 6'b0);
    rst_wen = 1'b1;
    rst_wdata = 1'b0;
    step();
    rst_wen = 1'b0;
    applyStimulus(4'b0000, 6'b001010);
    checkOutput("rw_miss_sum", rd_m[1], 32'd4);
    checkOutput("nop_clear_read_miss", rd_m[3], 32'd2);
    rst_wen = 1'b1;
    rst_wdata = 1'b1;
    applyStimulus(4'b0100, 6'b0);
    rst_wen = 1'b0;
    rst_wdata = 1'b0;
    applyStimulus(4'b0000, 6'b111111);
    checkOutput("clr_rvalid", {26'd0, rv_m}, 32'h3F);
    checkOutput("clr_rw_hit", rd_m[0], 32'd0);
    checkOutput("clr_rw_miss", rd_m[1], 32'd0);
    checkOutput("clr_read_miss", rd_m[3], 32'd0);
    checkOutput("clr_write_miss", rd_m[5], 32'd0);

    $display("[TB] wrap on 4-bit counters");
    for (int i = 0; i < 15; i++) applyStimulus(4'b1000, 6'b0);
    applyStimulus(4'b1010, 6'b0);
    applyStimulus(4'b0000, 6'b010101);
    checkOutput("wrap_rw_hit", {28'd0, rd_s[0]}, 32'd1);
    checkOutput("wrap_read_hit", {28'd0, rd_s[2]}, 32'd0);
    checkOutput("wrap_write_hit", {28'd0, rd_s[4]}, 32'd1);
    checkOutput("wide_rw_hit", rd_m[0], 32'd17);
    checkOutput("wide_read_hit", rd_m[2], 32'd16);

    $display("[TB] write-through buffer status reads");
    wtb_empty = 1'b1;
    wtb_full = 1'b0;
    wtb_ren = 2'b11;
    step();
    wtb_ren = 2'b00;
    checkOutput("wtb_read1", {28'd0, wtb_rv_m, wtb_rd_m}, 32'b1101);
    wtb_empty = 1'b0;
    wtb_full = 1'b1;
    step();
    checkOutput("wtb_hold", {28'd0, wtb_rv_m, wtb_rd_m}, 32'b0001);
    wtb_ren = 2'b11;
    step();
    wtb_ren = 2'b00;
    checkOutput("wtb_read2", {28'd0, wtb_rv_m, wtb_rd_m}, 32'b1110);
    wtb_full = 1'b0;

    $display("[TB] invalidate with wdata=0");
    inv_wen = 1'b1;
    inv_wdata = 1'b0;
    step();
    inv_wen = 1'b0;
    checkOutput("inv_nop_wready", {30'd0, inv_m, inv_wr_m}, 32'b01);

    $display("[TB] invalidate waiting on drain");
    wtb_empty = 1'b0;
    inv_wen = 1'b1;
    inv_wdata = 1'b1;
    step();
    inv_wen = 1'b0;
    inv_wdata = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_hold", {30'd0, inv_m, inv_wr_m}, 32'b00);
      step();
    end
    checkOutput("drain_hold_last", {30'd0, inv_m, inv_wr_m}, 32'b00);
    wtb_empty = 1'b1;
    step();
    checkOutput("inv_pulse", {30'd0, inv_m, inv_wr_m}, 32'b10);
    step();
    checkOutput("inv_done", {30'd0, inv_m, inv_wr_m}, 32'b01);

    $display("[TB] clock enable hold");
    inv_wen = 1'b1;
    inv_wdata = 1'b1;
    step();
    inv_wen = 1'b0;
    inv_wdata = 1'b0;
    checkOutput("cke_drain_entered", {30'd0, inv_m, inv_wr_m}, 32'b00);
    step();
    checkOutput("cke_inv", {30'd0, inv_m, inv_wr_m}, 32'b10);
    cke = 1'b0;
    step();
    step();
    checkOutput("cke_inv_held", {30'd0, inv_m, inv_wr_m}, 32'b10);
    cke = 1'b1;
    step();
    checkOutput("cke_inv_release", {30'd0, inv_m, inv_wr_m}, 32'b01);
    applyStimulus(4'b0000, 6'b000100);
    checkOutput("cke_rvalid_set", {26'd0, rv_m}, 32'b000100);
    cke = 1'b0;
    applyStimulus(4'b1000, 6'b0);
    checkOutput("cke_rvalid_held", {26'd0, rv_m}, 32'b000100);
    cke = 1'b1;
    step();
    checkOutput("cke_rvalid_drop", {26'd0, rv_m}, 32'd0);

    $display("[TB] reset during drain");
    wtb_empty = 1'b0;
    inv_wen = 1'b1;
    inv_wdata = 1'b1;
    step();
    inv_wen = 1'b0;
    inv_wdata = 1'b0;
    checkOutput("mid_drain", {30'd0, inv_m, inv_wr_m}, 32'b00);
    #2 arst = 1'b1;
    #1;
    checkOutput("mid_rst_idle", {30'd0, inv_m, inv_wr_m}, 32'b01);
    #2 arst = 1'b0;
    wtb_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("mid_rst_no_inv", {30'd0, inv_m, inv_wr_m}, 32'b01);
    end
    applyStimulus(4'b0000, 6'b111111);
    checkOutput("mid_rst_rvalid", {26'd0, rv_m}, 32'h3F);
    for (int i = 0; i < 6; i++) checkOutput("mid_rst_cnt_zero", rd_m[i], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_cache_ctrl_stats.md
# iob_cache_ctrl_stats

Statistics and maintenance back-end for the cache control interface. It sits directly downstream of the cache software register bank, serving its read ports (WTB status, hit/miss counters) and write ports (counter reset, invalidate). It counts the single-cycle hit/miss events from the cache front-end and sequences cache invalidation against the write-through buffer.

## Interface

**Parameters**
- `CNT_W`, 32: counter width; must equal the register-bank counter width.
- `USE_CTRL_CNT`, 1: when 0, counters are not built and read as 0; handshakes still respond.

**Ports**
- `clk_i`  in  1  clock.
- `cke_i`  in  1  clock enable; state holds when low.
- `arst_i`  in  1  asynchronous, active-high reset.
- `read_hit_i`, `read_miss_i`, `write_hit_i`, `write_miss_i`  in  1 each  event pulses from the cache, one per cycle per event; any combination may coincide.
- `wtb_empty_i`, `wtb_full_i`  in  1 each  write-through buffer status.
- `WTB_EMPTY_ren_i`, `WTB_FULL_ren_i`  in  1  read strobes.
- `WTB_EMPTY_rdata_o`, `WTB_FULL_rdata_o`  out  1  read data.
- `WTB_EMPTY_rvalid_o`, `WTB_FULL_rvalid_o`  out  1  read-data valid.
- `WTB_EMPTY_rready_o`, `WTB_FULL_rready_o`  out  1  read ready.
- For each counter `X` in {`RW_HIT`, `RW_MISS`, `READ_HIT`, `READ_MISS`, `WRITE_HIT`, `WRITE_MISS`}:
  - `X_ren_i`  in  1.
  - `X_rdata_o`  out  `CNT_W`.
  - `X_rvalid_o`  out  1.
  - `X_rready_o`  out  1.
- `RST_CNTRS_wdata_i`  in  1; `RST_CNTRS_wen_i`  in  1; `RST_CNTRS_wready_o`  out  1.
- `INVALIDATE_wdata_i`  in  1; `INVALIDATE_wen_i`  in  1; `INVALIDATE_wready_o`  out  1.
- `invalidate_o`  out  1  one-cycle invalidate command to the cache tag/valid memory.

## Operation

**Counters**
- `READ_HIT`, `READ_MISS`, `WRITE_HIT` and `WRITE_MISS` each increment by 1 on their own event.
- `RW_HIT` increments by `read_hit_i + write_hit_i`, i.e. by 0, 1 or 2.
- `RW_MISS` increments by `read_miss_i + write_miss_i`, i.e. by 0, 1 or 2.
- Arithmetic is modulo 2^`CNT_W`: all-ones plus 1 wraps to 0, and all-ones plus 2 wraps to 1.

**Counter reset**
- `RST_CNTRS_wen_i` with wdata=1 clears all six counters at the next edge.
- A clear wins over any event in the same cycle; that event is lost.
- wdata=0 is a no-op.
- `RST_CNTRS_wready_o` is constantly 1.

**Reads**
- On `X_ren_i`, the current register value (before this cycle's increment) is captured into a holding register.
- `X_rvalid_o` pulses for one cycle on the next edge, with `X_rdata_o` valid in that cycle.
- `X_rdata_o` holds its value until the next `ren` for that register.
- All `rready_o` are constantly 1.
- WTB status reads capture `wtb_empty_i` / `wtb_full_i` in the same way.

**Invalidate FSM** (states IDLE, DRAIN, INV)
- IDLE: on `INVALIDATE_wen_i` with wdata=1, go to DRAIN. wdata=0 stays in IDLE.
- DRAIN: wait until `wtb_empty_i`=1, then go to INV. DRAIN is entered and held even if the buffer is already empty.
- INV: `invalidate_o`=1 for exactly one cycle, then go to IDLE.
- `INVALIDATE_wready_o` = (state==IDLE).
- A `wen` while not in IDLE is a protocol violation; it is ignored and the bench asserts it never occurs.

## Timing

- **Reset values:**
  - All counters, all `rdata_o` and all `rvalid_o` reset to 0.
  - `invalidate_o` resets to 0.
  - The FSM resets to IDLE, so `INVALIDATE_wready_o`=1.
  - All `rready_o` and `RST_CNTRS_wready_o` are 1.
- **Event latency:** an event at edge N is visible in the counter after edge N, so a `ren` in cycle N+1 returns it.
- **Read latency:** `ren` in cycle N gives `rvalid` high in cycle N+1. Back-to-back `ren` gives back-to-back `rvalid`.
- **Invalidate latency:** with `wtb_empty_i` already high, `wen` at cycle N puts DRAIN at N+1, INV (`invalidate_o`=1) at N+2, and IDLE at N+3.
- **Reset mid-operation:** `arst_i` asserted in DRAIN or INV returns the FSM to IDLE immediately with `invalidate_o`=0; the pending invalidate is dropped.
- **Clock enable:** with `cke_i`=0, all registers hold, including pending `rvalid` and the FSM state.

## Structure

- Constants (`CNT_W` default, FSM state encodings) go in the shared `iob_cache_conf.vh` / `iob_cache_swreg_def.vh` headers.
- All flops are `iob_reg` with cke/arst.
- One sub-module is natural: `iob_cache_event_cnt`, a `CNT_W` counter with synchronous clear priority and a 2-bit increment input. It is instantiated six times and omitted by generate when `USE_CTRL_CNT`=0.

## Test plan

- **Coincident events:** 5 cycles of `read_hit_i`=`write_hit_i`=1, then `RW_HIT_ren_i` → `RW_HIT_rdata_o`=10, `READ_HIT`=5, `WRITE_HIT`=5, with `rvalid` one cycle after `ren`.
- **Wrap:** preload via 2^32−1 events (forced), then one more read hit plus write hit → `RW_HIT`=1, `READ_HIT`=0.
- **Clear priority:** `RST_CNTRS` wen with wdata=1 in the same cycle as `read_miss_i` → `READ_MISS`=0 and `RW_MISS`=0 on the next read.
- **Invalidate drain:** `wtb_empty_i`=0, INVALIDATE wen=1, hold for 4 cycles, then empty=1 → `wready` low throughout, `invalidate_o` high for exactly 1 cycle 1 cycle after empty rises, `wready` back high the cycle after.
- **Reset mid-invalidate:** `arst_i` pulse while in DRAIN → `invalidate_o` never asserts, `wready`=1 and all counters=0.
- **USE_CTRL_CNT=0:** events plus `ren` on all counters → `rdata`=0 and `rvalid` pulses one cycle after each `ren`.
